clps_tx_serializer: RTL

- Multi-lane CLPS transmit front end. Buffers parallel words, serializes each lane MSB-first at bit rate, and drives complementary outp/outm pairs toward the CLPS_Tx pad cells.
- Generalises the single-bit pad model in three ways: it has N lanes, a per-lane data inversion control, and a registered pre-emphasis strobe generator driven by PEmode.
- Sits between the DTU output formatter and the CLPS_Tx pad instances.

---
 rtl/clps_tx_serializer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/clps_tx_serializer.sv
// Multi-lane CLPS transmit serializer: shared word FIFO, MSB-first per-lane shifters,
// complementary outputs and pre-emphasis strobes. Define CLPS_TX_PRBS_EN for PRBS7 test mode.
module clps_tx_serializer #(
    parameter int unsigned       NLANES     = 4,
    parameter int unsigned       WORD_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD  = 32'hEAAAAAAA
) (
    input  logic                     ClkBitRate,
    input  logic                     rst_b,
    input  logic [NLANES*WORD_W-1:0] DataIn,
    input  logic                     DataValid,
    output logic                     DataReady,
    input  logic                     TxEn,
    input  logic [NLANES-1:0]        InvertData,
    input  logic [1:0]               PEmode,
    input  logic                     PrbsSel,
    output logic [NLANES-1:0]        outp,
    output logic [NLANES-1:0]        outm,
    output logic [NLANES-1:0]        PEpulse,
    output logic                     WordStrobe,
    output logic                     Underflow
);

    localparam int unsigned DataW  = NLANES * WORD_W;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(WORD_W);
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

    typedef enum logic [1:0] {StOff, StLoad, StRun} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     bitcnt_q, bitcnt_d;
    logic [DataW-1:0]    sr_q, sr_d;
    logic [NLANES-1:0]   outp_q, outp_d;
    logic [NLANES-1:0]   pe_q, pe_d;
    logic [NLANES-1:0]   prev_q, prev_d;
    logic [NLANES-1:0]   trans_q, trans_d;
    logic                word_strobe_q, word_strobe_d;
    logic                underflow_q, underflow_d;

    logic [DataW-1:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CountW-1:0]   count_q, count_d;
    logic                ready_q, ready_d;
    logic                wr_en, rd_en, reload, fifo_empty, prbs_on;
    logic [DataW-1:0]    fifo_head;
    logic [NLANES-1:0]   lane_bit, lane_trans;

`ifdef CLPS_TX_PRBS_EN
    logic [6:0] lfsr_q [NLANES];
    logic [6:0] lfsr_d [NLANES];

    assign prbs_on = PrbsSel;

    // x^7 + x^6 + 1, free-running only while serializing
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lfsr_d[k] = lfsr_q[k];
            if (state_q == StRun) begin
                lfsr_d[k] = {lfsr_q[k][5:0], lfsr_q[k][6] ^ lfsr_q[k][5]};
            end
        end
    end

    always_ff @(posedge ClkBitRate or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < NLANES; k++) begin
                lfsr_q[k] <= 7'(127 + k);
            end
        end else begin
            for (int k = 0; k < NLANES; k++) begin
                lfsr_q[k] <= lfsr_d[k];
            end
        end
    end
`else
    logic unused_prbs_sel;

    assign prbs_on         = 1'b0;
    assign unused_prbs_sel = PrbsSel;
`endif

    assign wr_en      = DataValid && ready_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rptr_q];

    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lane_bit[k] = sr_q[k*WORD_W + WORD_W - 1];
`ifdef CLPS_TX_PRBS_EN
            if (PrbsSel) begin
                lane_bit[k] = lfsr_q[k][6];
            end
`endif
        end
        lane_trans = lane_bit ^ prev_q;
    end

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        sr_d          = sr_q;
        outp_d        = '0;
        pe_d          = '0;
        prev_d        = prev_q;
        trans_d       = trans_q;
        word_strobe_d = 1'b0;
        underflow_d   = underflow_q;
        reload        = 1'b0;
        rd_en         = 1'b0;

        unique case (state_q)
            StOff: begin
                bitcnt_d    = '0;
                prev_d      = '0;
                trans_d     = '0;
                underflow_d = 1'b0;
                if (TxEn) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                reload   = 1'b1;
                state_d  = StRun;
                bitcnt_d = LastBit;
                prev_d   = '0;
                trans_d  = '0;
            end
            StRun: begin
                for (int k = 0; k < NLANES; k++) begin
                    outp_d[k]                = lane_bit[k] ^ InvertData[k];
                    sr_d[k*WORD_W +: WORD_W] = {sr_q[k*WORD_W +: WORD_W-1], 1'b0};
                end
                prev_d  = lane_bit;
                trans_d = lane_trans;
                case (PEmode)
                    2'b00:   pe_d = '0;
                    // also strobe the bit after a transition when it repeats the new level
                    2'b10:   pe_d = lane_trans | (trans_q & ~lane_trans);
                    default: pe_d = lane_trans;
                endcase
                word_strobe_d = (bitcnt_q == LastBit) && !prbs_on;
                bitcnt_d      = bitcnt_q - CntW'(1);
                if (bitcnt_q == '0) begin
                    reload   = 1'b1;
                    bitcnt_d = LastBit;
                    if (fifo_empty && !prbs_on) begin
                        underflow_d = 1'b1;
                    end
                end
            end
            default: state_d = StOff;
        endcase

        if (reload) begin
            if (!fifo_empty && !prbs_on) begin
                sr_d  = fifo_head;
                rd_en = 1'b1;
            end else begin
                sr_d = {NLANES{IDLE_WORD}};
            end
        end

        // Abort from any state; queued words stay in the FIFO.
        if (!TxEn) begin
            state_d       = StOff;
            bitcnt_d      = '0;
            outp_d        = '0;
            pe_d          = '0;
            prev_d        = '0;
            trans_d       = '0;
            word_strobe_d = 1'b0;
            underflow_d   = 1'b0;
            rd_en         = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = wptr_q + PtrW'(wr_en);
        rptr_d  = rptr_q + PtrW'(rd_en);
        count_d = count_q + CountW'(wr_en) - CountW'(rd_en);
        ready_d = (count_d != CountW'(FIFO_DEPTH));
    end

    always_ff @(posedge ClkBitRate) begin
        if (wr_en) begin
            mem_q[wptr_q] <= DataIn;
        end
    end

    always_ff @(posedge ClkBitRate or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= StOff;
            bitcnt_q      <= '0;
            sr_q          <= '0;
            outp_q        <= '0;
            pe_q          <= '0;
            prev_q        <= '0;
            trans_q       <= '0;
            word_strobe_q <= 1'b0;
            underflow_q   <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            sr_q          <= sr_d;
            outp_q        <= outp_d;
            pe_q          <= pe_d;
            prev_q        <= prev_d;
            trans_q       <= trans_d;
            word_strobe_q <= word_strobe_d;
            underflow_q   <= underflow_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
        end
    end

    assign outp       = outp_q;
    assign outm       = ~outp_q;
    assign PEpulse    = pe_q;
    assign WordStrobe = word_strobe_q;
    assign Underflow  = underflow_q;
    assign DataReady  = ready_q;

endmodule
